// File: rtl/console_key_sequencer.sv
// Front-panel console sequencer: synchronizes and debounces START/STOP/RESET/SINGLE STEP
// and runs the RUN/STOP state machine that gates CPU instruction cycles.
module console_key_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RESET_CYCLES    = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start_key_n,
  input  logic stop_key_n,
  input  logic reset_key_n,
  input  logic sstep_key_n,
  input  logic cycle_done,
  output logic cycle_en,
  output logic run_lamp,
  output logic prog_reset,
  output logic prog_reset_n
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);

  localparam int K_START = 0;
  localparam int K_STOP  = 1;
  localparam int K_RESET = 2;
  localparam int K_SSTEP = 3;

  localparam logic [2:0] S_RESET_HOLD = 3'd0;
  localparam logic [2:0] S_STOPPED    = 3'd1;
  localparam logic [2:0] S_RUNNING    = 3'd2;
  localparam logic [2:0] S_STOPPING   = 3'd3;
  localparam logic [2:0] S_STEPPING   = 3'd4;

  logic [3:0]    raw_n;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    db;
  logic [3:0]    press;
  logic [CW-1:0] db_cnt [4];

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;

  assign raw_n = {sstep_key_n, reset_key_n, stop_key_n, start_key_n};

  // Keys idle high, so released is the safe reset value for every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      db    <= '1;
      press <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the
      // two synchronizer stages stay two distinct registers regardless of statement order.
      sync1 <= raw_n;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
          press[i]  <= ~sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    state_nxt = state;
    hold_nxt  = hold_cnt;
    if (press[K_RESET]) begin
      state_nxt = S_RESET_HOLD;
      hold_nxt  = '0;
    end else begin
      case (state)
        S_RESET_HOLD: begin
          if (!db[K_RESET]) begin
            hold_nxt = '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state_nxt = S_STOPPED;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_cnt + HW'(1);
          end
        end
        S_STOPPED: begin
          // STOP outranks START, so a simultaneous STOP+START leaves the machine stopped.
          if (!press[K_STOP]) begin
            if (press[K_START])      state_nxt = S_RUNNING;
            else if (press[K_SSTEP]) state_nxt = S_STEPPING;
          end
        end
        S_RUNNING: begin
          if (press[K_STOP]) state_nxt = cycle_done ? S_STOPPED : S_STOPPING;
        end
        S_STOPPING: begin
          if (cycle_done) state_nxt = S_STOPPED;
        end
        S_STEPPING: begin
          if (press[K_STOP])   state_nxt = cycle_done ? S_STOPPED : S_STOPPING;
          else if (cycle_done) state_nxt = S_STOPPED;
        end
        default: begin
          state_nxt = S_RESET_HOLD;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they change with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RESET_HOLD;
      hold_cnt   <= '0;
      prog_reset <= 1'b1;
      cycle_en   <= 1'b0;
      run_lamp   <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      prog_reset <= (state_nxt == S_RESET_HOLD);
      cycle_en   <= (state_nxt == S_RUNNING) || (state_nxt == S_STEPPING);
      run_lamp   <= (state_nxt == S_RUNNING) || (state_nxt == S_STOPPING) ||
                    (state_nxt == S_STEPPING);
    end
  end

  assign prog_reset_n = ~prog_reset;

endmodule

// File: tb/tb_console_key_sequencer.sv
// Bench for console_key_sequencer: directed console scenarios plus random key/cycle_done
// traffic, all checked every cycle against a window-based behavioural model.
module tb_console_key_sequencer;

  localparam int D  = 4;
  localparam int RC = 8;

  localparam int K_START = 0;
  localparam int K_STOP  = 1;
  localparam int K_RESET = 2;
  localparam int K_SSTEP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_key_n = 1'b1;
  logic stop_key_n  = 1'b1;
  logic reset_key_n = 1'b1;
  logic sstep_key_n = 1'b1;
  logic cycle_done  = 1'b0;
  logic cycle_en;
  logic run_lamp;
  logic prog_reset;
  logic prog_reset_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  console_key_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .RESET_CYCLES   (RC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_key_n (start_key_n),
    .stop_key_n  (stop_key_n),
    .reset_key_n (reset_key_n),
    .sstep_key_n (sstep_key_n),
    .cycle_done  (cycle_done),
    .cycle_en    (cycle_en),
    .run_lamp    (run_lamp),
    .prog_reset  (prog_reset),
    .prog_reset_n(prog_reset_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_HOLD, M_STOPPED, M_RUNNING, M_STOPPING, M_STEPPING} mstate_t;

  mstate_t      m_st = M_HOLD;
  int           m_hold_left = RC;
  logic [D+1:0] m_hist [4];
  logic [3:0]   m_db = 4'hF;
  logic [3:0]   m_press = 4'h0;
  logic [3:0]   exp_q [$];

  // A key's accepted level flips once the synchronized samples (raw delayed two clocks)
  // have disagreed with it for D consecutive clocks.
  task automatic model_step();
    logic [3:0]   raw;
    logic [3:0]   pr;
    logic [3:0]   pdb;
    logic [D-1:0] win;
    raw = {sstep_key_n, reset_key_n, stop_key_n, start_key_n};
    if (rst) begin
      for (int k = 0; k < 4; k++) m_hist[k] = '1;
      m_db        = 4'hF;
      m_press     = 4'h0;
      m_st        = M_HOLD;
      m_hold_left = RC;
    end else begin
      pr  = m_press;
      pdb = m_db;
      if (pr[K_RESET]) begin
        m_st        = M_HOLD;
        m_hold_left = RC;
      end else begin
        case (m_st)
          M_HOLD: begin
            if (!pdb[K_RESET]) m_hold_left = RC;
            else begin
              m_hold_left--;
              if (m_hold_left == 0) m_st = M_STOPPED;
            end
          end
          M_STOPPED: begin
            if (pr[K_STOP])       m_st = M_STOPPED;
            else if (pr[K_START]) m_st = M_RUNNING;
            else if (pr[K_SSTEP]) m_st = M_STEPPING;
          end
          M_RUNNING:  if (pr[K_STOP]) m_st = cycle_done ? M_STOPPED : M_STOPPING;
          M_STOPPING: if (cycle_done) m_st = M_STOPPED;
          M_STEPPING: begin
            if (pr[K_STOP])  m_st = cycle_done ? M_STOPPED : M_STOPPING;
            else if (cycle_done) m_st = M_STOPPED;
          end
          default: m_st = M_HOLD;
        endcase
      end
      for (int k = 0; k < 4; k++) begin
        m_hist[k]  = {m_hist[k][D:0], raw[k]};
        win        = m_hist[k][D+1:2];
        m_press[k] = 1'b0;
        if (win == {D{~m_db[k]}}) begin
          m_db[k]    = ~m_db[k];
          m_press[k] = ~m_db[k];
        end
      end
    end
    exp_q.push_back({m_st == M_HOLD, m_st != M_HOLD,
                     (m_st == M_RUNNING) || (m_st == M_STEPPING),
                     (m_st == M_RUNNING) || (m_st == M_STOPPING) || (m_st == M_STEPPING)});
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: one expected output word per clock, compared mid-cycle.
  initial forever begin
    @(negedge clk);
    if (exp_q.size() != 0) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      check("outputs{prog_reset,prog_reset_n,cycle_en,run_lamp}",
            {prog_reset, prog_reset_n, cycle_en, run_lamp}, e);
    end
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: bench still running at t=%0t, expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int i;
    logic [3:0] lv;

    // 1. reset release and program-reset stretch
    tick(3);
    check("t1_prog_reset_in_rst", prog_reset, 1'b1);
    rst = 1'b0;
    for (i = 1; i <= 100; i++) begin
      tick(1);
      if (!prog_reset) break;
    end
    check("t1_prog_reset_clocks", i, RC);
    check("t1_cycle_en", cycle_en, 1'b0);
    check("t1_prog_reset_n", prog_reset_n, 1'b1);

    // 2. bouncy START, then steady press
    repeat (2) begin
      start_key_n = 1'b0; tick(D - 1);
      start_key_n = 1'b1; tick(D - 1);
    end
    check("t2_bounce_ignored", run_lamp, 1'b0);
    start_key_n = 1'b0;
    for (i = 0; i < 100; i++) begin
      tick(1);
      if (cycle_en) break;
    end
    check("t2_start_latency", i, D + 2);
    check("t2_run_lamp", run_lamp, 1'b1);
    tick(10);
    start_key_n = 1'b1;
    tick(10);
    check("t2_still_running", cycle_en, 1'b1);

    // 3. STOP lets the current instruction finish
    stop_key_n = 1'b0;
    for (i = 0; i < 100; i++) begin
      tick(1);
      if (!cycle_en) break;
    end
    check("t3_stop_latency", i, D + 2);
    check("t3_lamp_while_stopping", run_lamp, 1'b1);
    tick(9);
    check("t3_lamp_before_done", run_lamp, 1'b1);
    cycle_done = 1'b1; tick(1); cycle_done = 1'b0;
    check("t3_lamp_after_done", run_lamp, 1'b0);
    stop_key_n = 1'b1;
    tick(10);

    // 4. single step with the key held
    sstep_key_n = 1'b0;
    for (i = 0; i < 100; i++) begin
      tick(1);
      if (cycle_en) break;
    end
    check("t4_sstep_latency", i, D + 2);
    tick(3);
    cycle_done = 1'b1; tick(1); cycle_done = 1'b0;
    check("t4_stopped_after_done", {cycle_en, run_lamp}, 2'b00);
    repeat (3) begin
      tick(2);
      cycle_done = 1'b1; tick(1); cycle_done = 1'b0;
      check("t4_no_restart", cycle_en, 1'b0);
    end
    sstep_key_n = 1'b1;
    tick(10);

    // 5. RESET key held while running
    start_key_n = 1'b0; tick(D + 4);
    start_key_n = 1'b1; tick(D + 4);
    check("t5_running", cycle_en, 1'b1);
    reset_key_n = 1'b0;
    tick(20);
    check("t5_reset_held", prog_reset, 1'b1);
    reset_key_n = 1'b1;
    for (i = 0; i < 100; i++) begin
      tick(1);
      if (!prog_reset) break;
    end
    check("t5_release_to_stop", i, D + 1 + RC);
    check("t5_stopped", {cycle_en, run_lamp}, 2'b00);

    // 6. START and STOP together while stopped
    start_key_n = 1'b0;
    stop_key_n  = 1'b0;
    tick(12);
    check("t6_cycle_en", cycle_en, 1'b0);
    check("t6_run_lamp", run_lamp, 1'b0);
    start_key_n = 1'b1;
    stop_key_n  = 1'b1;
    tick(10);
    check("t6_after_release", cycle_en, 1'b0);

    // random traffic: bouncy keys, sporadic cycle_done and rare mid-run rst
    lv = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == K_RESET) begin
          if (lv[k] ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 5) == 0))
            lv[k] = ~lv[k];
        end else if ($urandom_range(0, 5) == 0) begin
          lv[k] = ~lv[k];
        end
      end
      {sstep_key_n, reset_key_n, stop_key_n, start_key_n} = lv;
      cycle_done = ($urandom_range(0, 7) == 0);
      rst        = ($urandom_range(0, 999) == 0);
      tick(1);
    end

    rst = 1'b0;
    {sstep_key_n, reset_key_n, stop_key_n, start_key_n} = 4'hF;
    cycle_done = 1'b0;
    tick(3);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
